// File: rtl/xdma_grant_tracker.sv
// Initiator-side grant tracker: parks local write requests until the remote grant arrives, then releases them.
// Optional grant timeout is compiled in with `define XDMA_GRANT_TIMEOUT_EN.
module xdma_grant_tracker #(
    parameter int unsigned NumPending    = 4,
    parameter int unsigned IdWidth       = 8,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [IdWidth-1:0]                req_id_i,
    input  logic [AddrWidth-1:0]              req_dst_addr_i,
    input  logic                              grant_valid_i,
    output logic                              grant_ready_o,
    input  logic [IdWidth-1:0]                grant_id_i,
    input  logic [AddrWidth-1:0]              grant_from_i,
    output logic                              go_valid_o,
    input  logic                              go_ready_i,
    output logic [IdWidth-1:0]                go_id_o,
    output logic [AddrWidth-1:0]              go_dst_addr_o,
    output logic [$clog2(NumPending+1)-1:0]   pending_cnt_o,
    output logic                              unmatched_o,
    output logic                              timeout_o,
    output logic [IdWidth-1:0]                timeout_id_o
);
    localparam int unsigned CntW  = $clog2(NumPending + 1);
    localparam int unsigned SlotW = (NumPending > 1) ? $clog2(NumPending) : 1;

    localparam logic [1:0] SLOT_FREE    = 2'd0;
    localparam logic [1:0] SLOT_WAIT    = 2'd1;
    localparam logic [1:0] SLOT_GRANTED = 2'd2;

    logic [1:0]           state_q [NumPending];
    logic [1:0]           state_d [NumPending];
    logic [IdWidth-1:0]   id_q    [NumPending];
    logic [AddrWidth-1:0] addr_q  [NumPending];

    logic             free_found, match_found, gnt_found, exp_found;
    logic [SlotW-1:0] free_idx, match_idx, gnt_idx, exp_idx;
    logic             alloc, matched, release_go;
    logic [CntW-1:0]  cnt_d;

    logic             go_valid_q;
    logic [SlotW-1:0] go_slot_q;
    logic             unmatched_q;

    // Descending scans so that the lowest index wins every priority pick.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        for (int i = NumPending - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = SlotW'(i);
            end
            if (state_q[i] == SLOT_WAIT && id_q[i] == grant_id_i && addr_q[i] == grant_from_i) begin
                match_found = 1'b1;
                match_idx   = SlotW'(i);
            end
            if (state_q[i] == SLOT_GRANTED) begin
                gnt_found = 1'b1;
                gnt_idx   = SlotW'(i);
            end
        end
    end

    assign req_ready_o   = rst_ni && free_found;
    assign grant_ready_o = rst_ni;
    assign alloc         = req_valid_i && req_ready_o;
    assign matched       = grant_valid_i && grant_ready_o && match_found;
    assign release_go    = go_valid_o && go_ready_i;

`ifdef XDMA_GRANT_TIMEOUT_EN
    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TMax = TW'(TimeoutCycles - 1);

    logic [TW-1:0] tcnt_q [NumPending];

    always_comb begin
        exp_found = 1'b0;
        exp_idx   = '0;
        for (int i = NumPending - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_WAIT && tcnt_q[i] == TMax &&
                !(matched && match_idx == SlotW'(i))) begin
                exp_found = 1'b1;
                exp_idx   = SlotW'(i);
            end
        end
    end

    // Counters saturate at the limit so that a delayed expiry is reported later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPending; i++) tcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumPending; i++) begin
                if (alloc && free_idx == SlotW'(i)) tcnt_q[i] <= '0;
                else if (state_q[i] == SLOT_WAIT && tcnt_q[i] != TMax) tcnt_q[i] <= tcnt_q[i] + TW'(1);
            end
        end
    end

    assign timeout_o    = exp_found;
    assign timeout_id_o = exp_found ? id_q[exp_idx] : '0;
`else
    assign exp_found    = 1'b0;
    assign exp_idx      = '0;
    assign timeout_o    = 1'b0;
    assign timeout_id_o = '0;
`endif

    // Each event acts on a slot in a distinct current state, so they never collide.
    always_comb begin
        for (int i = 0; i < NumPending; i++) state_d[i] = state_q[i];
        if (alloc)      state_d[free_idx]  = SLOT_WAIT;
        if (matched)    state_d[match_idx] = SLOT_GRANTED;
        if (release_go) state_d[go_slot_q] = SLOT_FREE;
        if (exp_found)  state_d[exp_idx]   = SLOT_FREE;
        cnt_d = '0;
        for (int i = 0; i < NumPending; i++) begin
            if (state_d[i] != SLOT_FREE) cnt_d = cnt_d + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPending; i++) begin
                state_q[i] <= SLOT_FREE;
                id_q[i]    <= '0;
                addr_q[i]  <= '0;
            end
            pending_cnt_o <= '0;
            unmatched_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NumPending; i++) state_q[i] <= state_d[i];
            if (alloc) begin
                id_q[free_idx]   <= req_id_i;
                addr_q[free_idx] <= req_dst_addr_i;
            end
            pending_cnt_o <= cnt_d;
            unmatched_q   <= grant_valid_i && grant_ready_o && !match_found;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            go_valid_q    <= 1'b0;
            go_slot_q     <= '0;
            go_id_o       <= '0;
            go_dst_addr_o <= '0;
        end else if (release_go) begin
            go_valid_q <= 1'b0;
        end else if (!go_valid_q && gnt_found) begin
            go_valid_q    <= 1'b1;
            go_slot_q     <= gnt_idx;
            go_id_o       <= id_q[gnt_idx];
            go_dst_addr_o <= addr_q[gnt_idx];
        end
    end

    assign go_valid_o  = go_valid_q;
    assign unmatched_o = unmatched_q;

endmodule
